// File: rtl/kronos_mem_arbiter.sv
// Arbitrates one single-port 32b memory between instruction fetch and LSU data.
// Data wins ties, except that a burst counter forces a fetch grant after MAX_DATA_BURST data grants.
module kronos_mem_arbiter #(
  parameter int MAX_DATA_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_addr,
  input  logic        instr_req,
  output logic        instr_ack,
  output logic [31:0] instr_data,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_wr_mask,
  input  logic        data_wr_en,
  input  logic        data_req,
  output logic        data_ack,
  output logic [31:0] data_rd_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_wr_mask,
  output logic        mem_wr_en,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [31:0] mem_rd_data
);

  localparam int CW = $clog2(MAX_DATA_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_DATA_BURST);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] burst_cnt, burst_nxt;
  logic          grant_i;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{instr_addr[1:0], data_addr[1:0]};

  // Fetch wins only when data is absent or has used up its burst allowance.
  assign grant_i = instr_req && (!data_req || (burst_cnt == BURST_MAX));

  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (grant_i) begin
          state_nxt = BUSY_I;
          burst_nxt = '0;
        end else if (data_req) begin
          state_nxt = BUSY_D;
          if (!instr_req)
            burst_nxt = '0;
          else if (burst_cnt != BURST_MAX)
            burst_nxt = burst_cnt + CW'(1);
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_wr_mask = '0;
    mem_wr_en   = 1'b0;
    case (state)
      BUSY_I: begin
        mem_req  = 1'b1;
        mem_addr = {instr_addr[31:2], 2'b00};
      end
      BUSY_D: begin
        mem_req     = 1'b1;
        mem_addr    = {data_addr[31:2], 2'b00};
        mem_wr_data = data_wr_data;
        mem_wr_mask = data_wr_mask;
        mem_wr_en   = data_wr_en;
      end
      default: ;
    endcase
  end

  assign instr_ack    = (state == BUSY_I) && mem_ack;
  assign data_ack     = (state == BUSY_D) && mem_ack;
  assign instr_data   = mem_rd_data;
  assign data_rd_data = mem_rd_data;

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// Directed bench for kronos_mem_arbiter: abstract owner/burst model checked every cycle,
// plus literal expectations for reset, latency, priority, starvation and address masking.
module tb_kronos_mem_arbiter;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_addr, data_addr, data_wr_data;
  logic [3:0]  data_wr_mask;
  logic        instr_req, data_req, data_wr_en;
  logic        instr_ack, data_ack;
  logic [31:0] instr_data, data_rd_data;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
  logic [3:0]  mem_wr_mask;
  logic        mem_wr_en, mem_req, mem_ack;

  int n_checks = 0;
  int n_fail   = 0;

  // memory responder: ack after lat cycles of mem_req, or manual drive
  int   lat = 1;
  int   wait_cnt = 0;
  logic resp_en = 1'b1;
  logic mem_ack_man = 1'b0;

  assign mem_ack = resp_en ? (mem_req && (wait_cnt == lat)) : mem_ack_man;

  always @(posedge clk)
    wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;

  always #5 clk = ~clk;

  kronos_mem_arbiter #(.MAX_DATA_BURST(MAX)) dut (
    .clk(clk), .rst(rst),
    .instr_addr(instr_addr), .instr_req(instr_req), .instr_ack(instr_ack), .instr_data(instr_data),
    .data_addr(data_addr), .data_wr_data(data_wr_data), .data_wr_mask(data_wr_mask),
    .data_wr_en(data_wr_en), .data_req(data_req), .data_ack(data_ack), .data_rd_data(data_rd_data),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_mask(mem_wr_mask),
    .mem_wr_en(mem_wr_en), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rd_data(mem_rd_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // model: owner 0=none, 1=instr, 2=data; m_cnt = data grants since fetch got a turn
  int m_owner = 0;
  int m_cnt   = 0;

  always @(negedge clk) begin
    chk("mdl_mem_req", {31'b0, mem_req}, {31'b0, m_owner != 0});
    chk("mdl_instr_ack", {31'b0, instr_ack}, {31'b0, (m_owner == 1) && mem_ack});
    chk("mdl_data_ack", {31'b0, data_ack}, {31'b0, (m_owner == 2) && mem_ack});
    chk("mdl_instr_data", instr_data, mem_rd_data);
    chk("mdl_data_rd_data", data_rd_data, mem_rd_data);
    if (m_owner == 1) begin
      chk("mdl_addr_i", mem_addr, instr_addr & ~32'h3);
      chk("mdl_wr_en_i", {31'b0, mem_wr_en}, 32'd0);
      chk("mdl_mask_i", {28'b0, mem_wr_mask}, 32'd0);
    end else if (m_owner == 2) begin
      chk("mdl_addr_d", mem_addr, data_addr & ~32'h3);
      chk("mdl_wr_en_d", {31'b0, mem_wr_en}, {31'b0, data_wr_en});
      chk("mdl_mask_d", {28'b0, mem_wr_mask}, {28'b0, data_wr_mask});
      chk("mdl_wdata_d", mem_wr_data, data_wr_data);
    end
    if (rst) begin
      m_owner = 0;
      m_cnt   = 0;
    end else if (m_owner != 0) begin
      if (mem_ack) m_owner = 0;
    end else if (instr_req && (!data_req || m_cnt >= MAX)) begin
      m_owner = 1;
      m_cnt   = 0;
    end else if (data_req) begin
      m_owner = 2;
      m_cnt   = instr_req ? ((m_cnt + 1 > MAX) ? MAX : m_cnt + 1) : 0;
    end
  end

  task automatic wait_ack(input bit want_data, input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(want_data ? data_ack : instr_ack) && n < bound);
    if (!(want_data ? data_ack : instr_ack)) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_%s: no ack within %0d cycles", want_data ? "data" : "instr", bound);
    end
  endtask

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int    n;
    string order;
    rst = 1'b1;
    instr_addr = 32'h0000_0300; instr_req = 1'b1;
    data_addr = 32'h0000_0010; data_wr_data = 32'hA5A5_0001; data_wr_mask = 4'b1111;
    data_wr_en = 1'b1; data_req = 1'b1;
    mem_rd_data = 32'h0;
    lat = 1;

    // 1: reset with both requests pending
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_acks", {30'b0, instr_ack, data_ack}, 32'd0);
    next_drive();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_first_idle", {31'b0, mem_req}, 32'd0);
    @(negedge clk);
    chk("rst_first_req", {31'b0, mem_req}, 32'd1);
    chk("rst_first_to_data", mem_addr, 32'h0000_0010);
    chk("rst_first_wr_en", {31'b0, mem_wr_en}, 32'd1);
    wait_ack(1'b1, 20, n);
    next_drive();
    data_req = 1'b0;
    wait_ack(1'b0, 20, n);
    chk("rst_then_instr", mem_addr, 32'h0000_0300);
    next_drive();
    instr_req = 1'b0;
    next_drive();

    // 2: fetch only, memory latency 2
    lat = 2;
    mem_rd_data = 32'hDEAD_BEEF;
    instr_addr = 32'h0000_0100;
    instr_req = 1'b1;
    @(negedge clk);
    chk("i_arb_cycle", {31'b0, mem_req}, 32'd0);
    @(negedge clk);
    chk("i_mem_req", {31'b0, mem_req}, 32'd1);
    chk("i_mem_addr", mem_addr, 32'h0000_0100);
    chk("i_wr_en", {31'b0, mem_wr_en}, 32'd0);
    wait_ack(1'b0, 20, n);
    chk("i_latency", n, 32'd2);
    chk("i_data", instr_data, 32'hDEAD_BEEF);
    chk("i_no_data_ack", {31'b0, data_ack}, 32'd0);
    next_drive();
    instr_req = 1'b0;
    next_drive();

    // 3: simultaneous store and fetch -> data first
    lat = 1;
    data_addr = 32'h0000_0040; data_wr_data = 32'h1234_5678; data_wr_mask = 4'b0011;
    data_wr_en = 1'b1; data_req = 1'b1;
    instr_addr = 32'h0000_0200; instr_req = 1'b1;
    wait_ack(1'b1, 20, n);
    chk("s_d_addr", mem_addr, 32'h0000_0040);
    chk("s_d_wr_en", {31'b0, mem_wr_en}, 32'd1);
    chk("s_d_mask", {28'b0, mem_wr_mask}, 32'h3);
    chk("s_d_wdata", mem_wr_data, 32'h1234_5678);
    next_drive();
    data_req = 1'b0;
    wait_ack(1'b0, 20, n);
    chk("s_i_addr", mem_addr, 32'h0000_0200);
    chk("s_i_wr_en", {31'b0, mem_wr_en}, 32'd0);
    next_drive();
    instr_req = 1'b0;
    next_drive();

    // 4: starvation guard with zero-latency memory
    lat = 0;
    data_addr = 32'h0000_0800; data_wr_en = 1'b0; data_wr_mask = 4'b0000;
    data_req = 1'b1; instr_addr = 32'h0000_0900; instr_req = 1'b1;
    order = "";
    n = 0;
    while (order.len() < 6 && n < 100) begin
      @(negedge clk);
      n++;
      if (data_ack) order = {order, "D"};
      if (instr_ack) order = {order, "I"};
    end
    n_checks++;
    if (order != "DDDDID") begin
      n_fail++;
      $display("FAIL burst_order: got %s expected DDDDID", order);
    end
    next_drive();
    data_req = 1'b0;
    instr_req = 1'b0;
    next_drive();

    // 5: reset while data access is outstanding; late ack ignored
    resp_en = 1'b0;
    mem_ack_man = 1'b0;
    data_addr = 32'h0000_0080; data_wr_en = 1'b0; data_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < 20);
    chk("r_busy", {31'b0, mem_req}, 32'd1);
    next_drive();
    rst = 1'b1;
    next_drive();
    rst = 1'b0;
    data_req = 1'b0;
    mem_ack_man = 1'b1;
    @(negedge clk);
    chk("r_mem_req", {31'b0, mem_req}, 32'd0);
    chk("r_data_ack", {31'b0, data_ack}, 32'd0);
    next_drive();
    mem_ack_man = 1'b0;
    @(negedge clk);
    chk("r_stays_idle", {31'b0, mem_req}, 32'd0);
    next_drive();
    resp_en = 1'b1;

    // 6: unaligned load address is masked
    lat = 3;
    mem_rd_data = 32'hCAFE_F00D;
    data_addr = 32'h0000_0103; data_wr_en = 1'b0; data_req = 1'b1;
    wait_ack(1'b1, 20, n);
    chk("a_mem_addr", mem_addr, 32'h0000_0100);
    chk("a_rd_data", data_rd_data, 32'hCAFE_F00D);
    chk("a_latency", n, 32'd5);
    next_drive();
    data_req = 1'b0;
    repeat (3) next_drive();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
